microcode_sequencer_stk: RTL
============================

Name: microcode_sequencer_stk

Overview:
- Parametrised next-generation microcode sequencer. It generates the control-store address for the external microcode ROM every clock.
- Adds the following:
  - generic address width;
  - two's-complement relative branches;
  - an N-deep micro-call/return stack;
  - conditional calls;
  - an extensible external-condition vector;
  - a stall hold;
  - sticky stack error flags.
- Sits between the control-word decode and the microcode ROM. It also owns the u_flags register.

Parameters:
- UADDR_W, 14, micro-address width.
- OFFSET_W, 7, width of ctrl_offset (signed).
- IR_W, 8, instruction register width.
- NUM_EXT_COND, 7, number of external condition inputs.
- STACK_DEPTH, 4, micro-return stack entries (≥1).
- RESET_ADDR, 0, u_address after reset.
- FETCH_ADDR, 0x10, fetch entry point.
- TRAP_ADDR, 0x20, interrupt/DMA trap entry.
- IR_BASE, 0x400, dispatch base added to ir.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst  in  1  reset. Synchronous and active-high.
- stall  in  1  freeze all sequencer state this cycle.
- ir  in  IR_W  opcode for dispatch.
- ctrl_typ  in  3  sequencing type.
- ctrl_offset  in  OFFSET_W  signed relative offset.
- ctrl_cond_sel  in  CSEL_W = $clog2(7+NUM_EXT_COND)  condition index.
- ctrl_cond_invert  in  1  invert the selected condition.
- ctrl_cond_flag_src  in  1  flag source for conditions: 0 = alu_flags, 1 = u_flags.
- alu_flags  in  4  {of,sf,cf,zf} from the ALU.
- alu_final_cf, alu_of  in  1 each  ALU carry and overflow.
- alu_out  in  8  ALU result.
- z_bus  in  8  Z bus.
- ctrl_u_zf_in_src  in  2  u_zf update source.
- ctrl_u_cf_in_src  in  2  u_cf update source.
- ctrl_u_sf_in_src  in  1  u_sf update source.
- ctrl_u_of_in_src  in  1  u_of update source.
- cond_ext  in  NUM_EXT_COND  external conditions (dma_req, mode, WAIT, int_pending, …).
- dma_req, int_pending  in  1 each  interruption requests.
- err_clr  in  1  clear the sticky error flags.
- ctrl_loop_load  in  1  load the loop counter (optional feature only).
- ctrl_immy  in  8  loop counter load value (optional feature only).
- u_address  out  UADDR_W  current micro-address to the ROM.
- u_flags  out  4  {of,sf,cf,zf} micro-flags.
- stack_level  out  $clog2(STACK_DEPTH+1)  entries in use.
- err_overflow  out  1  sticky stack overflow.
- err_underflow  out  1  sticky stack underflow.
- loop_count  out  8  loop counter value.

Behaviour:
- Reset (arst=1 at the clock edge):
  - u_address=RESET_ADDR, u_flags=0, stack_level=0, errors=0, loop_count=0.
  - Reset overrides stall and everything else.
- Stall: when stall=1 and arst=0, all registers hold, including u_flags, stack, errors and loop_count.
- Condition vector c (index = ctrl_cond_sel). Flags f come from alu_flags or u_flags according to ctrl_cond_flag_src.
  - 0: zf
  - 1: cf
  - 2: sf
  - 3: of
  - 4: sf^of
  - 5: (sf^of)|zf
  - 6: cf|zf
  - 7..6+NUM_EXT_COND: cond_ext[i-7]
  - Index beyond that range: 0.
  - Final condition cond = c[sel] ^ ctrl_cond_invert. It is combinational within the cycle.
- Next address. All arithmetic is modulo 2^UADDR_W; offsets are sign-extended; wrap-around is silent. Let ua = u_address.
  - 000 JMP: ua + offset.
  - 001 BR: cond ? ua + offset : ua + 1.
  - 010 FETCH: (dma_req|int_pending) ? TRAP_ADDR : FETCH_ADDR.
  - 011 DISPATCH: IR_BASE + zero-extended ir.
  - 100 CALL: push ua+1, then go to ua + offset.
  - 101 RET: pop the top of stack and go there.
  - 110 CCALL: if cond, behaves as CALL; else ua + 1 with no push.
  - 111 LOOP: see Optional Feature.
- Stack is LIFO; stack_level increments on push and decrements on pop.
  - Push with stack_level == STACK_DEPTH: entry discarded, the branch is still taken, err_overflow set.
  - RET with stack_level == 0: go to FETCH_ADDR, err_underflow set, level stays 0.
- Error flags: sticky until err_clr=1 or reset. Same-cycle set and clear → set wins.
- u_flags update each non-stalled edge:
  - zf src: 00 hold, 01 alu zf, 10 alu zf & u_zf, 11 hold.
  - cf src: 00 hold, 01 alu_final_cf, 10 alu_out[0], 11 alu_out[7].
  - sf src: 0 hold, 1 z_bus[7].
  - of src: 0 hold, 1 alu_of.
- Branch conditions use the pre-edge u_flags value.

Optional Feature:
- Macro: USEQ_LOOP_EN.
- Enabled:
  - ctrl_loop_load=1 loads loop_count ← ctrl_immy.
  - Type 111: if loop_count ≠ 0, loop_count decrements and the sequencer branches to ua + offset; else ua + 1.
  - A load takes priority over a decrement in the same cycle.
- Disabled:
  - Type 111 behaves as ua + 1.
  - loop_count is tied to 0.
  - ctrl_loop_load and ctrl_immy are ignored.

Test Plan:
- Reset, then JMP with offset=+5 from 0, then JMP with offset=-3 (0x7D) → u_address goes 0 → 5 → 2. With ua=0x3FFF and offset=+1 → u_address wraps to 0.
- BR: cond_sel=0, flag_src=0, alu zf=1, invert=0, ua=0x40, offset=4 → 0x44. Same with invert=1 → 0x41.
- FETCH with int_pending=1 → u_address=0x20. With no request → 0x10. DISPATCH with ir=0x3A → 0x43A.
- Nesting and overflow (STACK_DEPTH=4):
  - CALL nested 4 deep, then RET ×4 → each return hits its caller+1 and stack_level goes 4 → 0.
  - A 5th CALL → err_overflow=1 and the branch is still taken.
  - RET on an empty stack → u_address=0x10 and err_underflow=1; err_clr then clears both flags.
- stall=1 for 3 cycles during a CALL → u_address, stack_level and u_flags are unchanged. arst asserted mid-sequence → all outputs return to their reset values at the next edge.
- USEQ_LOOP_EN: load 3, then LOOP with offset=-1 → branch taken 3 times with loop_count 3 → 2 → 1 → 0, then falls through to ua + 1.

Source files
------------

// File: rtl/microcode_sequencer_stk.sv
// rtl/microcode_sequencer_stk.sv - microcode address sequencer with call/return stack and u_flags
// Optional loop counter enabled by defining USEQ_LOOP_EN.
module microcode_sequencer_stk #(
    parameter int UADDR_W      = 14,
    parameter int OFFSET_W     = 7,
    parameter int IR_W         = 8,
    parameter int NUM_EXT_COND = 7,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_ADDR   = 0,
    parameter int FETCH_ADDR   = 'h10,
    parameter int TRAP_ADDR    = 'h20,
    parameter int IR_BASE      = 'h400,
    localparam int CSEL_W      = $clog2(7 + NUM_EXT_COND),
    localparam int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    stall,
    input  logic [IR_W-1:0]         ir,
    input  logic [2:0]              ctrl_typ,
    input  logic [OFFSET_W-1:0]     ctrl_offset,
    input  logic [CSEL_W-1:0]       ctrl_cond_sel,
    input  logic                    ctrl_cond_invert,
    input  logic                    ctrl_cond_flag_src,
    input  logic [3:0]              alu_flags,
    input  logic                    alu_final_cf,
    input  logic                    alu_of,
    input  logic [7:0]              alu_out,
    input  logic [7:0]              z_bus,
    input  logic [1:0]              ctrl_u_zf_in_src,
    input  logic [1:0]              ctrl_u_cf_in_src,
    input  logic                    ctrl_u_sf_in_src,
    input  logic                    ctrl_u_of_in_src,
    input  logic [NUM_EXT_COND-1:0] cond_ext,
    input  logic                    dma_req,
    input  logic                    int_pending,
    input  logic                    err_clr,
    input  logic                    ctrl_loop_load,
    input  logic [7:0]              ctrl_immy,
    output logic [UADDR_W-1:0]      u_address,
    output logic [3:0]              u_flags,
    output logic [LVL_W-1:0]        stack_level,
    output logic                    err_overflow,
    output logic                    err_underflow,
    output logic [7:0]              loop_count
);
    localparam int NUM_COND = 7 + NUM_EXT_COND;
    localparam logic [UADDR_W-1:0] A_RST   = RESET_ADDR[UADDR_W-1:0];
    localparam logic [UADDR_W-1:0] A_FETCH = FETCH_ADDR[UADDR_W-1:0];
    localparam logic [UADDR_W-1:0] A_TRAP  = TRAP_ADDR[UADDR_W-1:0];
    localparam logic [UADDR_W-1:0] A_IRB   = IR_BASE[UADDR_W-1:0];
    localparam logic [UADDR_W-1:0] A_ONE   = UADDR_W'(1);
    localparam logic [LVL_W-1:0]   LVL_FULL = STACK_DEPTH[LVL_W-1:0];

    logic [3:0]          f;
    logic [NUM_COND-1:0] cvec;
    logic                cond;
    logic [UADDR_W-1:0]  off_ext, ua_inc, ua_rel, top, nxt;
    logic                push, pop, full, set_ovf, set_unf, loop_dec;
    logic [3:0]          nxt_flags;
    logic [UADDR_W-1:0]  stk [STACK_DEPTH];

    // f = {of, sf, cf, zf}
    assign f    = ctrl_cond_flag_src ? u_flags : alu_flags;
    assign cvec = {cond_ext, f[1] | f[0], (f[2] ^ f[3]) | f[0], f[2] ^ f[3], f[3], f[2], f[1], f[0]};
    assign cond = ((int'(ctrl_cond_sel) < NUM_COND) ? cvec[ctrl_cond_sel] : 1'b0) ^ ctrl_cond_invert;

    assign off_ext = UADDR_W'($signed(ctrl_offset));
    assign ua_inc  = u_address + A_ONE;
    assign ua_rel  = u_address + off_ext;
    assign full    = (stack_level == LVL_FULL);

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (stack_level == LVL_W'(i + 1)) top = stk[i];
    end

    always_comb begin
        nxt      = ua_inc;
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        loop_dec = 1'b0;
        case (ctrl_typ)
            3'b000: nxt = ua_rel;
            3'b001: if (cond) nxt = ua_rel;
            3'b010: nxt = (dma_req | int_pending) ? A_TRAP : A_FETCH;
            3'b011: nxt = A_IRB + UADDR_W'(ir);
            3'b100: begin
                nxt  = ua_rel;
                push = 1'b1;
            end
            3'b101: begin
                if (stack_level == '0) begin
                    nxt     = A_FETCH;
                    set_unf = 1'b1;
                end else begin
                    nxt = top;
                    pop = 1'b1;
                end
            end
            3'b110: if (cond) begin
                nxt  = ua_rel;
                push = 1'b1;
            end
            default: begin
`ifdef USEQ_LOOP_EN
                if (loop_count != 8'd0) begin
                    nxt      = ua_rel;
                    loop_dec = 1'b1;
                end
`endif
            end
        endcase
        if (push && full) set_ovf = 1'b1;
    end

    always_comb begin
        nxt_flags = u_flags;
        case (ctrl_u_zf_in_src)
            2'b01:   nxt_flags[0] = alu_flags[0];
            2'b10:   nxt_flags[0] = alu_flags[0] & u_flags[0];
            default: nxt_flags[0] = u_flags[0];
        endcase
        case (ctrl_u_cf_in_src)
            2'b01:   nxt_flags[1] = alu_final_cf;
            2'b10:   nxt_flags[1] = alu_out[0];
            2'b11:   nxt_flags[1] = alu_out[7];
            default: nxt_flags[1] = u_flags[1];
        endcase
        if (ctrl_u_sf_in_src) nxt_flags[2] = z_bus[7];
        if (ctrl_u_of_in_src) nxt_flags[3] = alu_of;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            u_address     <= A_RST;
            u_flags       <= 4'b0;
            stack_level   <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (!stall) begin
            u_address <= nxt;
            u_flags   <= nxt_flags;
            if (push && !full)
                stack_level <= stack_level + LVL_W'(1);
            else if (pop)
                stack_level <= stack_level - LVL_W'(1);
            // set wins over a same-cycle clear
            err_overflow  <= set_ovf | (err_overflow & ~err_clr);
            err_underflow <= set_unf | (err_underflow & ~err_clr);
        end
    end

    // Stack storage needs no reset: entries above stack_level are never read.
    always_ff @(posedge clk) begin
        if (!arst && !stall && push && !full)
            for (int i = 0; i < STACK_DEPTH; i++)
                if (stack_level == LVL_W'(i)) stk[i] <= ua_inc;
    end

`ifdef USEQ_LOOP_EN
    always_ff @(posedge clk) begin
        if (arst)
            loop_count <= 8'd0;
        else if (!stall) begin
            if (ctrl_loop_load)
                loop_count <= ctrl_immy;
            else if (loop_dec)
                loop_count <= loop_count - 8'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{alu_out[6:1], z_bus[6:0], loop_dec};
`else
    assign loop_count = 8'd0;

    logic unused_bits;
    assign unused_bits = ^{alu_out[6:1], z_bus[6:0], loop_dec, ctrl_loop_load, ctrl_immy};
`endif
endmodule
